// File: rtl/strike_collector.sv
// strike_collector
//
// Collects strike requests from up to eight puzzle modules and issues them
// one at a time to the strike counter. A minimum spacing is enforced between
// issued strikes.
//
// Each module input is rising-edge detected. A captured edge sets that
// module's pending bit. The FSM (IDLE -> ISSUE -> HOLDOFF) grants the
// lowest-index pending bit, produces a one-clock strike pulse tagged with its
// one-hot source, and then holds off for HOLDOFF_CYCLES clocks.
//
// Optional feature, enabled by defining the macro STRIKE_BUZZER_EN: a buzzer
// output that is driven high for BUZZ_CYCLES clocks from each ISSUE clock. A
// new ISSUE while the buzzer is on restarts the on-time.
//
// Parameters
//   NUM_MODULES    : number of strike sources (1..8)
//   HOLDOFF_CYCLES : clocks of holdoff after each strike (>= 1)
//   BUZZ_CYCLES    : buzzer on-time per strike (>= 1)
//
// Ports
//   clock         : system clock
//   reset         : synchronous, active-high reset
//   enable        : game running; strikes are captured only while high
//   module_strike : per-module strike request level
//   strike        : one-clock pulse per accepted strike
//   strike_src    : one-hot source of the current strike, zero otherwise
//   buzzer        : buzzer drive (only with STRIKE_BUZZER_EN)
//   busy          : high while issuing, holding off, or any request pending
module strike_collector #(
    parameter int NUM_MODULES    = 6,
    parameter int HOLDOFF_CYCLES = 2700000,
    parameter int BUZZ_CYCLES    = 13500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_MODULES-1:0] module_strike,
    output logic                   strike,
    output logic [NUM_MODULES-1:0] strike_src,
`ifdef STRIKE_BUZZER_EN
    output logic                   buzzer,
`endif
    output logic                   busy
);

    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          hold_cnt_r;
    logic [NUM_MODULES-1:0] history_r;
    logic [NUM_MODULES-1:0] pending_r;

    logic [NUM_MODULES-1:0] rise_s;
    logic [NUM_MODULES-1:0] grant_s;
    logic [NUM_MODULES-1:0] pending_next_s;
    logic                   hold_done_s;
    logic                   take_s;

    // Edge detect, lowest-index grant and next pending vector.
    always_comb begin
        rise_s  = module_strike & ~history_r;
        grant_s = '0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = NUM_MODULES - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                grant_s    = '0;
                grant_s[i] = 1'b1;
            end else begin
                grant_s = grant_s;
            end
        end
        hold_done_s = (state_r == HOLDOFF) && (hold_cnt_r == HOLD_LAST);
        // A grant can happen from IDLE, or directly at the end of HOLDOFF so
        // queued strikes are exactly HOLDOFF_CYCLES+1 clocks apart.
        take_s = (|pending_r) && ((state_r == IDLE) || hold_done_s);
        if (enable) begin
            // A new edge ORed in after the clear wins over a same-cycle grant.
            pending_next_s = (pending_r & ~(take_s ? grant_s : {NUM_MODULES{1'b0}})) | rise_s;
        end else begin
            pending_next_s = '0;
        end
    end

    // Edge history tracks the input even in reset so held levels stay silent.
    always_ff @(posedge clock) begin
        history_r <= module_strike;
    end

    // Main FSM, pending register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            hold_cnt_r <= '0;
            pending_r  <= '0;
            strike     <= 1'b0;
            strike_src <= '0;
            busy       <= 1'b0;
        end else begin
            pending_r  <= pending_next_s;
            strike     <= take_s;
            strike_src <= take_s ? grant_s : {NUM_MODULES{1'b0}};
            busy       <= take_s || (state_r == ISSUE) ||
                          ((state_r == HOLDOFF) && !hold_done_s) || (|pending_next_s);
            case (state_r)
                IDLE: begin
                    hold_cnt_r <= '0;
                    state_r    <= take_s ? ISSUE : IDLE;
                end
                ISSUE: begin
                    hold_cnt_r <= '0;
                    state_r    <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (hold_done_s) begin
                        hold_cnt_r <= '0;
                        state_r    <= take_s ? ISSUE : IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + CW'(1);
                        state_r    <= HOLDOFF;
                    end
                end
                default: begin
                    hold_cnt_r <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

`ifdef STRIKE_BUZZER_EN
    localparam int BW = $clog2(BUZZ_CYCLES + 1);

    logic [BW-1:0] buzz_cnt_r;

    // Buzzer on-time counter; counts remaining clocks after the current one.
    always_ff @(posedge clock) begin
        if (reset) begin
            buzzer     <= 1'b0;
            buzz_cnt_r <= '0;
        end else if (take_s) begin
            buzzer     <= 1'b1;
            buzz_cnt_r <= BW'(BUZZ_CYCLES - 1);
        end else if (buzzer) begin
            if (buzz_cnt_r == '0) begin
                buzzer <= 1'b0;
            end else begin
                buzz_cnt_r <= buzz_cnt_r - BW'(1);
            end
        end else begin
            buzz_cnt_r <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_strike_collector.sv
// Directed testbench for strike_collector (HOLDOFF_CYCLES=8, BUZZ_CYCLES=20).
// Inputs change 1 time unit after a rising edge; outputs are read either at
// that point or on the falling edge. cyc counts rising edges seen so far.
module tb_strike_collector;

    localparam int N = 6;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] module_strike;
    logic         strike;
    logic [N-1:0] strike_src;
    logic         busy;
`ifdef STRIKE_BUZZER_EN
    logic         buzzer;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int           sq_cyc[$];
    logic [N-1:0] sq_src[$];
    int           buzz_count = 0;
    int           buzz_first = -1;
    int           buzz_last  = -1;

    strike_collector #(
        .NUM_MODULES   (N),
        .HOLDOFF_CYCLES(8),
        .BUZZ_CYCLES   (20)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .module_strike(module_strike),
        .strike       (strike),
        .strike_src   (strike_src),
`ifdef STRIKE_BUZZER_EN
        .buzzer       (buzzer),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log every strike pulse and buzzer activity on the falling edge.
    always @(negedge clock) begin
        if (strike) begin
            sq_cyc.push_back(cyc);
            sq_src.push_back(strike_src);
        end
`ifdef STRIKE_BUZZER_EN
        if (buzzer) begin
            buzz_count = buzz_count + 1;
            if (buzz_first < 0) buzz_first = cyc;
            buzz_last = cyc;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int m);
        while (cyc < m) step();
    endtask

    task automatic check_strikes(input string tag, input int n,
                                 input int c0, input logic [N-1:0] s0,
                                 input int c1, input logic [N-1:0] s1,
                                 input int c2, input logic [N-1:0] s2);
        int exp_c[3];
        logic [N-1:0] exp_s[3];
        exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2;
        check({tag, "_count"}, sq_cyc.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < sq_cyc.size()) begin
                check($sformatf("%s_cyc%0d", tag, i), sq_cyc[i], exp_c[i]);
                check($sformatf("%s_src%0d", tag, i), {26'd0, sq_src[i]}, {26'd0, exp_s[i]});
            end
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        enable = 1'b0;
        module_strike = 6'b000000;
        step(); step(); step();
        check("rst_strike", strike, 1'b0);
        check("rst_src", strike_src, 6'b000000);
        check("rst_busy", busy, 1'b0);
`ifdef STRIKE_BUZZER_EN
        check("rst_buzzer", buzzer, 1'b0);
`endif
        reset = 1'b0;
        enable = 1'b1;
        step(); step();

        // Single held level: one strike two cycles after the edge.
        sq_cyc.delete(); sq_src.delete();
        n = cyc;
        module_strike = 6'b000100;
        step();
        check("t1_busy_up", busy, 1'b1);
        wait_until(n + 50);
        check_strikes("t1", 1, n + 2, 6'b000100, 0, 6'b0, 0, 6'b0);
        check("t1_busy_down", busy, 1'b0);
        module_strike = 6'b000000;
        wait_until(n + 60);

        // Simultaneous edges: ascending order, 9 clocks apart.
        sq_cyc.delete(); sq_src.delete();
        n = cyc;
        module_strike = 6'b101001;
        wait_until(n + 40);
        check_strikes("t2", 3, n + 2, 6'b000001, n + 11, 6'b001000, n + 20, 6'b100000);
        module_strike = 6'b000000;
        wait_until(n + 45);

        // Merged re-edges on pending bit 1, then an edge coinciding with grant.
        sq_cyc.delete(); sq_src.delete();
        n = cyc;
        module_strike = 6'b000011;
        wait_until(n + 3);  module_strike = 6'b000001;
        wait_until(n + 4);  module_strike = 6'b000011;
        wait_until(n + 5);  module_strike = 6'b000001;
        wait_until(n + 6);  module_strike = 6'b000011;
        wait_until(n + 9);  module_strike = 6'b000001;
        wait_until(n + 10); module_strike = 6'b000011;
        wait_until(n + 40);
        check_strikes("t3", 3, n + 2, 6'b000001, n + 11, 6'b000010, n + 20, 6'b000010);
        module_strike = 6'b000000;
        wait_until(n + 45);

        // Edge while disabled is ignored; a fresh edge after enable counts.
        sq_cyc.delete(); sq_src.delete();
        n = cyc;
        enable = 1'b0;
        module_strike = 6'b000001;
        wait_until(n + 3);
        enable = 1'b1;
        wait_until(n + 25);
        check("t4_no_strike", sq_cyc.size(), 0);
        check("t4_idle", busy, 1'b0);
        module_strike = 6'b000000;
        wait_until(n + 26);
        module_strike = 6'b000001;
        wait_until(n + 40);
        check_strikes("t4", 1, n + 28, 6'b000001, 0, 6'b0, 0, 6'b0);
        module_strike = 6'b000000;
        wait_until(n + 45);

        // Reset mid-holdoff with bit 2 pending.
        sq_cyc.delete(); sq_src.delete();
        n = cyc;
        module_strike = 6'b000101;
        wait_until(n + 4);
        check("t5_busy_holdoff", busy, 1'b1);
        wait_until(n + 5);
        reset = 1'b1;
        wait_until(n + 6);
        check("t5_strike0", strike, 1'b0);
        check("t5_src0", strike_src, 6'b000000);
        check("t5_busy0", busy, 1'b0);
        wait_until(n + 8);
        reset = 1'b0;
        wait_until(n + 40);
        check_strikes("t5", 1, n + 2, 6'b000001, 0, 6'b0, 0, 6'b0);
        check("t5_busy_end", busy, 1'b0);
        module_strike = 6'b000000;
        wait_until(n + 45);

`ifdef STRIKE_BUZZER_EN
        // Two strikes 9 apart keep the buzzer on for 9 + 20 clocks.
        sq_cyc.delete(); sq_src.delete();
        buzz_count = 0; buzz_first = -1; buzz_last = -1;
        n = cyc;
        module_strike = 6'b001001;
        wait_until(n + 50);
        check_strikes("t6", 2, n + 2, 6'b000001, n + 11, 6'b001000, 0, 6'b0);
        check("t6_buzz_first", buzz_first, n + 2);
        check("t6_buzz_count", buzz_count, 29);
        check("t6_buzz_span", buzz_last - buzz_first + 1, 29);
        check("t6_buzz_off", buzzer, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strike_collector.md
STRIKE_COLLECTOR -- requirements
Module: strike_collector

Interface
REQ-001 Parameter NUM_MODULES, default 6: number of puzzle modules reporting strikes (1..8).
REQ-002 Parameter HOLDOFF_CYCLES, default 2700000: minimum clocks between issued strikes (100 ms at 27 MHz).
REQ-003 Parameter BUZZ_CYCLES, default 13500000: buzzer on-time per strike (500 ms at 27 MHz).
REQ-004 clock  input  1  system clock, 27 MHz.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 enable  input  1  game running; strikes are captured only while high.
REQ-007 module_strike  input  NUM_MODULES  per-module strike request, level, any duration.
REQ-008 strike  output  1  one-clock pulse per accepted strike; feeds the strike counter.
REQ-009 strike_src  output  NUM_MODULES  one-hot source of the current strike; zero otherwise.
REQ-010 busy  output  1  high while in ISSUE or HOLDOFF, or while any pending bit is set.
REQ-011 buzzer  output  1  strike buzzer drive (present only per REQ-027).

Function
REQ-012 Each module_strike bit SHALL be rising-edge detected against its value on the previous clock; levels held high SHALL produce exactly one event.
REQ-013 A rising edge sampled while enable=1 SHALL set that module's pending bit on the same clock edge.
REQ-014 A second edge on a module whose pending bit is already set SHALL be merged (no extra strike).
REQ-015 FSM states: IDLE, ISSUE, HOLDOFF; reset state IDLE.
REQ-016 IDLE -> ISSUE when any pending bit is set; the lowest-index pending bit is granted and cleared.
REQ-017 ISSUE lasts exactly one clock: strike=1, strike_src=one-hot of the granted bit; then -> HOLDOFF.
REQ-018 HOLDOFF counts HOLDOFF_CYCLES clocks with strike=0, then -> IDLE; counter width SHALL be clog2(HOLDOFF_CYCLES+1); no wrap.
REQ-019 Latency: a rising edge sampled in cycle k with the FSM in IDLE and no lower pending bit SHALL give strike=1 in cycle k+2.
REQ-020 If a pending bit is cleared by grant in the same cycle that a new edge arrives on that module, the new edge SHALL win (bit remains set).
REQ-021 Simultaneous edges on several modules SHALL each yield one strike, issued in ascending index order, HOLDOFF_CYCLES+1 clocks apart (ISSUE clock plus HOLDOFF).
REQ-022 enable=0 SHALL clear all pending bits and block capture; an ISSUE or HOLDOFF already in progress SHALL complete normally.
REQ-023 Edges occurring while enable=0 SHALL NOT be captured when enable returns high, even if the input is still high.
REQ-024 strike and strike_src SHALL be registered outputs, zero in every state except ISSUE.

Reset
REQ-025 reset SHALL take priority over all other logic: state IDLE, pending=0, holdoff counter=0, strike=0, strike_src=0, busy=0, buzzer=0.
REQ-026 Edge-detect history SHALL load the current module_strike value during reset, so inputs already high at reset release generate no strike.

Configuration
REQ-027 Macro STRIKE_BUZZER_EN: when defined, buzzer SHALL go high on the ISSUE clock for BUZZ_CYCLES clocks; a new ISSUE while buzzing SHALL restart the count.
REQ-028 Without STRIKE_BUZZER_EN, the buzzer port and its counter SHALL be absent; all other behaviour is unchanged.

Verification (use HOLDOFF_CYCLES=8, BUZZ_CYCLES=20 in the bench)
REQ-029 Reset, enable=1, module_strike=6'b000100 rising at cycle 10 and held 50 clocks -> one strike pulse at cycle 12, strike_src=6'b000100, no further pulses.
REQ-030 module_strike 6'b000000 -> 6'b101001 in one clock -> three strikes, src 000001, 001000, 100000, exactly 9 clocks apart.
REQ-031 Bit 1 pulsed twice within one HOLDOFF while bit 1 is still pending -> exactly one strike from bit 1.
REQ-032 enable=0, bit 0 rises and stays high, enable=1 -> no strike; bit 0 falls and rises again -> one strike.
REQ-033 reset asserted mid-HOLDOFF with bit 2 pending -> all outputs 0 next clock; no strike after release while inputs stay constant.
REQ-034 STRIKE_BUZZER_EN defined: two strikes 9 clocks apart -> buzzer high continuously for 29 clocks from the first ISSUE.
